// File: rtl/ahb_master_if.sv
`default_nettype none
// ============================================================================
// Module : ahb_master_if
// Desc   : AHB-Lite bus signal bundle with master and slave views.
// Rev    : 1.0  initial release
// ============================================================================
interface ahb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [1:0]        htrans;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        output haddr, hwrite, hsize, hburst, htrans, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, htrans, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface
`default_nettype wire

// File: rtl/ahb_master.sv
`default_nettype none
// ============================================================================
// Module : ahb_master
// Desc   : AHB-Lite master turning single client commands into word bursts.
// Rev    : 1.0  initial release
// ============================================================================
module ahb_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire                 hclk,
    input  wire                 hresetn,
    input  wire                 cmd_valid,
    output logic                cmd_ready,
    input  wire                 cmd_write,
    input  wire  [ADDR_W-1:0]   cmd_addr,
    input  wire  [2:0]          cmd_burst,
    input  wire  [4:0]          cmd_len,
    input  wire  [DATA_W-1:0]   wr_data,
    output logic                wr_req,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                err,
    ahb_master_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            state_q;
    logic [ADDR_W-1:0] haddr_q;
    logic              hwrite_q;
    logic [2:0]        hburst_q;
    logic [1:0]        htrans_q;
    logic [DATA_W-1:0] hwdata_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              done_q;
    logic              err_q;
    logic              cmd_ready_q;
    logic [4:0]        beats_q;

    logic [4:0]        cmd_beats_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [ADDR_W-1:0] wrap_mask_d;
    logic [ADDR_W-1:0] haddr_inc_d;
    logic [ADDR_W-1:0] haddr_d;

    always_comb begin
        cmd_beats_d = 5'd1;
        case (cmd_burst)
            3'b001:         cmd_beats_d = (cmd_len == 5'd0) ? 5'd1 : cmd_len;
            3'b010, 3'b011: cmd_beats_d = 5'd4;
            3'b100, 3'b101: cmd_beats_d = 5'd8;
            3'b110, 3'b111: cmd_beats_d = 5'd16;
            default:        cmd_beats_d = 5'd1;
        endcase
    end

    // WRAP-N keeps the upper bits and wraps within a 4N-byte window.
    always_comb begin
        wrap_mask_d = '0;
        case (hburst_q)
            3'b010:  wrap_mask_d = ADDR_W'(32'h0F);
            3'b100:  wrap_mask_d = ADDR_W'(32'h1F);
            3'b110:  wrap_mask_d = ADDR_W'(32'h3F);
            default: wrap_mask_d = '0;
        endcase
    end

    assign cmd_addr_d  = cmd_addr & ~ADDR_W'(3);
    assign haddr_inc_d = haddr_q + ADDR_W'(4);
    assign haddr_d     = (wrap_mask_d != '0)
                       ? ((haddr_q & ~wrap_mask_d) | (haddr_inc_d & wrap_mask_d))
                       : haddr_inc_d;

    assign wr_req    = htrans_q[1] & bus.hready & hwrite_q;
    assign cmd_ready = cmd_ready_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign err       = err_q;

    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = 3'b010;
    assign bus.hburst    = hburst_q;
    assign bus.htrans    = htrans_q;
    assign bus.hprot     = 4'b0011;
    assign bus.hmastlock = 1'b0;
    assign bus.hwdata    = hwdata_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hburst_q    <= 3'b000;
            htrans_q    <= HT_IDLE;
            hwdata_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            beats_q     <= 5'd0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            if (wr_req) begin
                hwdata_q <= wr_data;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= S_ADDR;
                        cmd_ready_q <= 1'b0;
                        htrans_q    <= HT_NONSEQ;
                        haddr_q     <= cmd_addr_d;
                        hwrite_q    <= cmd_write;
                        hburst_q    <= cmd_burst;
                        beats_q     <= cmd_beats_d;
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        if (beats_q == 5'd1) begin
                            state_q  <= S_LAST;
                            htrans_q <= HT_IDLE;
                        end else begin
                            state_q  <= S_BURST;
                            htrans_q <= HT_SEQ;
                            haddr_q  <= haddr_d;
                            beats_q  <= beats_q - 5'd1;
                        end
                    end
                end
                S_BURST, S_LAST: begin
                    // The pending address phase is dropped as soon as ERROR shows.
                    if (bus.hresp) begin
                        htrans_q <= HT_IDLE;
                        if (bus.hready) begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                        end
                    end else if (bus.hready) begin
                        if (!hwrite_q) begin
                            rd_data_q  <= bus.hrdata;
                            rd_valid_q <= 1'b1;
                        end
                        if (state_q == S_LAST) begin
                            state_q     <= S_IDLE;
                            cmd_ready_q <= 1'b1;
                            done_q      <= 1'b1;
                        end else if (beats_q == 5'd1) begin
                            state_q  <= S_LAST;
                            htrans_q <= HT_IDLE;
                        end else begin
                            haddr_q <= haddr_d;
                            beats_q <= beats_q - 5'd1;
                        end
                    end
                end
                S_ERR: begin
                    if (bus.hready) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                        err_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    htrans_q    <= HT_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master.sv
`default_nettype none
// Testbench for ahb_master: directed command table, a mid-burst reset sequence
// and randomized commands checked against an address/timing model of the bus.
module tb_ahb_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [2:0]  cmd_burst;
    logic [4:0]  cmd_len;
    logic [31:0] wr_data;
    logic        cmd_ready;
    logic        wr_req;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic        err;

    ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_burst (cmd_burst),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic             wr;
        logic [31:0]      addr;
        logic [2:0]       burst;
        logic [4:0]       len;
        logic [31:0]      wd0;
        int               wait_cyc;
        int               err_beat;
        int               exp_done;
        logic             exp_err;
        int               exp_nrd;
        int               exp_nwr;
        int               exp_nacc;
        logic [3:0][31:0] exp_a;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          obs_done, obs_nrd, obs_nwr, obs_nacc, obs_waits;
    logic        obs_err;
    logic [31:0] obs_addr [$];
    logic [31:0] salt;
    vec_t        vec [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int model_beats(input logic [2:0] b, input logic [4:0] len);
        if (b == 3'd0) return 1;
        if (b == 3'd1) return (len == 5'd0) ? 1 : int'(len);
        return 4 << ((int'(b) >> 1) - 1);
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] start, input logic [2:0] b,
                                               input int n, input int i);
        logic [31:0] s, span, base;
        s = start & ~32'h3;
        if (b != 3'd0 && !b[0]) begin
            span = 32'(4 * n);
            base = s - (s % span);
            return base + ((s - base + 32'(4 * i)) % span);
        end
        return s + 32'(4 * i);
    endfunction

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ salt;
    endfunction

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                                input logic [4:0] len, input int wait_cyc, input int err_beat,
                                input int exp_done, input logic exp_err, input int nrd,
                                input int nwr, input int nacc, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        vec_t v;
        v.wr = wr; v.addr = addr; v.burst = burst; v.len = len; v.wd0 = 32'hDEAD_BEEF;
        v.wait_cyc = wait_cyc; v.err_beat = err_beat; v.exp_done = exp_done; v.exp_err = exp_err;
        v.exp_nrd = nrd; v.exp_nwr = nwr; v.exp_nacc = nacc;
        v.exp_a[0] = a0; v.exp_a[1] = a1; v.exp_a[2] = a2; v.exp_a[3] = a3;
        return v;
    endfunction

    // Drives one command and plays the slave; cycle 1 is the first cycle after accept.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] burst,
                           input logic [4:0] len, input logic [31:0] wd0, input int wait_cyc,
                           input int err_beat, input int wait_pct);
        logic [31:0] wdat [0:31];
        logic [31:0] pend_addr, prev_addr;
        logic        pend_v, pend_wr, prev_stall, prev_resp;
        logic [1:0]  prev_trans;
        int          n, pend_idx, err_st;
        n = model_beats(burst, len);
        foreach (wdat[k]) wdat[k] = $urandom;
        wdat[0] = wd0;
        salt = $urandom;
        obs_addr.delete();
        obs_done = -1; obs_err = 1'b0; obs_nrd = 0; obs_nwr = 0; obs_nacc = 0; obs_waits = 0;
        pend_v = 1'b0; pend_wr = 1'b0; pend_addr = '0; pend_idx = 0; err_st = 0;
        prev_stall = 1'b0; prev_resp = 1'b0; prev_addr = '0; prev_trans = 2'b00;
        @(negedge hclk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_burst = burst; cmd_len = len;
        wr_data = wdat[0]; bus.hready = 1'b1; bus.hresp = 1'b0;
        @(negedge hclk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c == 1) begin
                chk("first_nonseq", bus.htrans, 2'b10);
                chk("first_addr", bus.haddr, model_addr(addr, burst, n, 0));
                chk("busy_not_ready", cmd_ready, 0);
            end
            if (err_st != 0) chk("idle_after_error", bus.htrans, 2'b00);
            if (prev_stall && !prev_resp && prev_trans[1]) begin
                chk("hold_addr", bus.haddr, prev_addr);
                chk("hold_trans", bus.htrans, prev_trans);
            end
            if (rd_valid) begin
                chk("rd_data", rd_data, rdata_of(model_addr(addr, burst, n, obs_nrd)));
                obs_nrd++;
            end
            if (done) begin
                obs_done = c;
                obs_err  = err;
                chk("ready_at_done", cmd_ready, 1);
                break;
            end
            bus.hresp = 1'b0; bus.hready = 1'b1;
            if (err_st == 1) begin
                bus.hresp = 1'b1; err_st = 2;
            end else if (pend_v && pend_idx == err_beat && err_st == 0) begin
                bus.hready = 1'b0; bus.hresp = 1'b1; err_st = 1;
            end else if (c == wait_cyc || int'($urandom_range(99)) < wait_pct) begin
                bus.hready = 1'b0;
            end
            bus.hrdata = rdata_of(pend_addr);
            wr_data = wdat[obs_nwr & 31];
            #1;
            if (wr_req) obs_nwr++;
            if (!bus.hready) obs_waits++;
            if (bus.hready) begin
                if (pend_v && pend_wr && !bus.hresp) chk("hwdata", bus.hwdata, wdat[pend_idx]);
                pend_v = 1'b0;
                if (bus.htrans[1]) begin
                    chk("beat_addr", bus.haddr, model_addr(addr, burst, n, obs_nacc));
                    chk("beat_trans", bus.htrans, (obs_nacc == 0) ? 2'b10 : 2'b11);
                    chk("beat_write", bus.hwrite, wr);
                    obs_addr.push_back(bus.haddr);
                    pend_v = 1'b1; pend_addr = bus.haddr; pend_wr = bus.hwrite;
                    pend_idx = obs_nacc; obs_nacc++;
                end
            end
            prev_stall = !bus.hready; prev_resp = bus.hresp;
            prev_addr = bus.haddr; prev_trans = bus.htrans;
            @(negedge hclk);
        end
        bus.hready = 1'b1; bus.hresp = 1'b0;
        if (obs_done < 0) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done seen, expected done within cycle budget");
            hresetn = 1'b0;
            @(negedge hclk);
            hresetn = 1'b1;
        end
    endtask

    initial begin
        logic saw;
        hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_burst = '0;
        cmd_len = '0; wr_data = '0; bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0; salt = '0;
        repeat (3) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rst_htrans", bus.htrans, 0);     chk("rst_haddr", bus.haddr, 0);
        chk("rst_hwrite", bus.hwrite, 0);     chk("rst_hburst", bus.hburst, 0);
        chk("rst_hwdata", bus.hwdata, 0);     chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);     chk("rst_wr_req", wr_req, 0);
        chk("rst_done", done, 0);             chk("rst_err", err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);   chk("hsize_word", bus.hsize, 3'b010);
        chk("hprot_fixed", bus.hprot, 4'b0011); chk("hmastlock_fixed", bus.hmastlock, 0);

        vec[0] = mk(1, 32'h1000, 3'b000, 0, 0, -1,  3, 0,  0, 1, 1, 32'h1000, 0, 0, 0);
        vec[1] = mk(0, 32'h0038, 3'b010, 0, 2, -1,  7, 0,  4, 0, 4, 32'h38, 32'h3C, 32'h30, 32'h34);
        vec[2] = mk(1, 32'h0100, 3'b101, 0, 0, -1, 10, 0,  0, 8, 8, 32'h100, 32'h104, 32'h108, 32'h10C);
        vec[3] = mk(0, 32'h0200, 3'b011, 0, 0,  1,  5, 1,  1, 0, 2, 32'h200, 32'h204, 0, 0);
        vec[4] = mk(0, 32'h0040, 3'b001, 0, 0, -1,  3, 0,  1, 0, 1, 32'h40, 0, 0, 0);
        vec[5] = mk(1, 32'h007C, 3'b100, 0, 0, -1, 10, 0,  0, 8, 8, 32'h7C, 32'h60, 32'h64, 32'h68);
        vec[6] = mk(0, 32'h00F6, 3'b110, 0, 0, -1, 18, 0, 16, 0, 16, 32'hF4, 32'hF8, 32'hFC, 32'hC0);
        vec[7] = mk(1, 32'h03F0, 3'b001, 3, 1, -1,  6, 0,  0, 3, 3, 32'h3F0, 32'h3F4, 32'h3F8, 0);
        vec[8] = mk(0, 32'h0800, 3'b111, 0, 0,  0,  4, 1,  0, 0, 1, 32'h800, 0, 0, 0);
        vec[9] = mk(1, 32'h0C00, 3'b000, 0, 0,  0,  4, 1,  0, 1, 1, 32'hC00, 0, 0, 0);

        // Reset during the third address phase of an INCR16 read.
        @(negedge hclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h400; cmd_burst = 3'b111; cmd_len = 0;
        @(negedge hclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge hclk);
        chk("mid_burst_seq", bus.htrans, 2'b11);
        chk("mid_burst_addr", bus.haddr, 32'h408);
        hresetn = 1'b0;
        #1;
        chk("async_rst_htrans", bus.htrans, 0);
        chk("async_rst_haddr", bus.haddr, 0);
        chk("async_rst_cmd_ready", cmd_ready, 1);
        chk("async_rst_done", done, 0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge hclk);
            if (done || bus.htrans != 2'b00) saw = 1'b1;
        end
        chk("quiet_after_reset", saw, 0);

        for (int t = 0; t < 10; t++) begin
            run_cmd(vec[t].wr, vec[t].addr, vec[t].burst, vec[t].len, vec[t].wd0,
                    vec[t].wait_cyc, vec[t].err_beat, 0);
            chk("tbl_done_cycle", obs_done, vec[t].exp_done);
            chk("tbl_err", obs_err, vec[t].exp_err);
            chk("tbl_rd_valid_count", obs_nrd, vec[t].exp_nrd);
            chk("tbl_wr_req_count", obs_nwr, vec[t].exp_nwr);
            chk("tbl_addr_count", obs_nacc, vec[t].exp_nacc);
            for (int k = 0; k < 4 && k < vec[t].exp_nacc; k++)
                chk("tbl_addr", obs_addr[k], vec[t].exp_a[k]);
        end

        for (int r = 0; r < 40; r++) begin
            logic        wr;
            logic [2:0]  b;
            logic [4:0]  len;
            logic [31:0] a;
            int          n, eb, ne;
            wr  = 1'($urandom_range(1));
            b   = 3'($urandom_range(7));
            len = 5'($urandom_range(16));
            n   = model_beats(b, len);
            a   = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(255 - n)) << 2)
                | 32'($urandom_range(3));
            eb  = ($urandom_range(3) == 0) ? int'($urandom_range(n - 1)) : -1;
            ne  = (eb >= 0) ? eb + 1 : n;
            run_cmd(wr, a, b, len, $urandom, 0, eb, int'($urandom_range(40)));
            chk("rnd_done_cycle", obs_done, ne + 2 + obs_waits);
            chk("rnd_err", obs_err, (eb >= 0));
            chk("rnd_rd_valid_count", obs_nrd, wr ? 0 : ((eb >= 0) ? eb : n));
            chk("rnd_wr_req_count", obs_nwr, wr ? ne : 0);
            chk("rnd_addr_count", obs_nacc, ne);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
